// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the four-digit seven-segment scanner.
package seven_seg_pkg;

  localparam int unsigned DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_t;

  localparam logic [3:0] ANODE_OFF   = 4'b1111;
  localparam logic [3:0] ANODE_SLOT0 = 4'b1110;
  localparam logic [3:0] ANODE_SLOT1 = 4'b1101;
  localparam logic [3:0] ANODE_SLOT2 = 4'b1011;
  localparam logic [3:0] ANODE_SLOT3 = 4'b0111;

  // Active-low strobe pattern for a slot index.
  function automatic logic [3:0] slot_anode(input logic [1:0] sel);
    logic [3:0] pattern;
    case (sel)
      2'd0:    pattern = ANODE_SLOT0;
      2'd1:    pattern = ANODE_SLOT1;
      2'd2:    pattern = ANODE_SLOT2;
      default: pattern = ANODE_SLOT3;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Loadable up-counter with clear; flags the final cycle of a dwell of 'limit' cycles.
module dwell_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count_next_c,
  output logic             last_c
);

  logic [WIDTH-1:0] count;

  always_comb begin
    count_next_c = count + WIDTH'(1);
    if (clear) begin
      count_next_c = '0;
    end else if (load) begin
      count_next_c = load_value;
    end
  end

  assign last_c = (count == limit - WIDTH'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      count <= count_next_c;
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed anode scanner: blanking dead-time, per-digit masking and
// 16-level PWM brightness; every output is a flop fed from next-state values.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [3:0] digit_en,
  input  logic [3:0] brightness,
  output logic [3:0] anode,
  output logic [1:0] digit_sel,
  output logic       frame_tick
);

  localparam int unsigned MAX_DWELL = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CW        = $clog2(MAX_DWELL + 1);
  localparam int unsigned PW        = CW + 5;

  state_t          state, state_next;
  logic            clear, last;
  logic [CW-1:0]   limit, count_next;
  logic [1:0]      sel_next;
  logic [3:0]      bright_s, bright_next;
  logic            en_s, en_next;
  logic [PW-1:0]   duty_prod;
  logic [CW-1:0]   thr_next;
  logic [3:0]      anode_next;
  logic            tick_next;

  assign limit = (state == ON) ? CW'(REFRESH_DIV) : CW'(BLANK_CYCLES);

  dwell_counter #(.WIDTH(CW)) u_dwell (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .load         (1'b0),
    .load_value   ('0),
    .limit        (limit),
    .count_next_c (count_next),
    .last_c       (last)
  );

  // Next state, slot sampling and next output values.
  always_comb begin
    state_next  = state;
    clear       = 1'b0;
    sel_next    = digit_sel;
    bright_next = bright_s;
    en_next     = en_s;

    if (!enable) begin
      state_next = IDLE;
      clear      = 1'b1;
      sel_next   = 2'd0;
    end else begin
      case (state)
        IDLE: begin
          clear      = 1'b1;
          state_next = (BLANK_CYCLES == 0) ? ON : BLANK;
        end
        BLANK: begin
          if (last) begin
            clear      = 1'b1;
            state_next = ON;
          end
        end
        ON: begin
          if (last) begin
            clear      = 1'b1;
            sel_next   = digit_sel + 2'd1;
            state_next = (BLANK_CYCLES == 0) ? ON : BLANK;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // Entering an ON phase always coincides with a counter clear.
    if (state_next == ON && clear) begin
      bright_next = brightness;
      en_next     = digit_en[sel_next];
    end

    duty_prod = (PW'(bright_next) + PW'(1)) * PW'(REFRESH_DIV);
    thr_next  = CW'(duty_prod >> 4);

    anode_next = ANODE_OFF;
    if (state_next == ON && en_next && count_next < thr_next) begin
      anode_next = slot_anode(sel_next);
    end

    tick_next = (state_next == ON) && (sel_next == 2'd3) &&
                (count_next == CW'(REFRESH_DIV - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      digit_sel  <= 2'd0;
      bright_s   <= 4'd0;
      en_s       <= 1'b0;
      anode      <= ANODE_OFF;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_next;
      digit_sel  <= sel_next;
      bright_s   <= bright_next;
      en_s       <= en_next;
      anode      <= anode_next;
      frame_tick <= tick_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: a frame-timeline model predicts anode, digit_sel
// and frame_tick every cycle under directed and random stimulus.
module tb_seven_seg_scanner;

  localparam int RD    = 32;
  localparam int BC    = 4;
  localparam int SLOT  = RD + BC;
  localparam int FRAME = 4 * SLOT;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] digit_en = 4'hf;
  logic [3:0] brightness = 4'hf;
  logic [3:0] anode;
  logic [1:0] digit_sel;
  logic       frame_tick;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: cycle index since scanning started, plus values latched at slot start.
  int         m_t = 0;
  bit         m_active = 1'b0;
  int         m_b = 0;
  bit         m_en = 1'b0;
  logic [3:0] exp_anode;
  logic [1:0] exp_sel;
  logic       exp_ft;

  seven_seg_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .digit_en   (digit_en),
    .brightness (brightness),
    .anode      (anode),
    .digit_sel  (digit_sel),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // One clock edge, then recompute the expected outputs from the frame timeline.
  task automatic advance();
    int p, slot, w;
    @(posedge clk);
    #1;
    if (!reset_n || !enable) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_t = 0;
    end else begin
      m_t++;
    end
    exp_anode = 4'b1111;
    exp_sel   = 2'd0;
    exp_ft    = 1'b0;
    if (m_active) begin
      p    = m_t % FRAME;
      slot = p / SLOT;
      w    = p % SLOT;
      if (w == BC) begin
        m_b  = int'(brightness);
        m_en = digit_en[slot];
      end
      exp_sel = 2'(slot);
      exp_ft  = (slot == 3) && (w == SLOT - 1);
      if (w >= BC && m_en && (w - BC) < ((m_b + 1) * RD) / 16) exp_anode[slot] = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    enable = 1'b0;
    #1;
    n_checks++; if (anode !== 4'b1111) $display("FAIL reset_async anode got %b exp 1111", anode); else n_pass++;
    repeat (3) begin
      advance();
      n_checks++; if (anode !== exp_anode) $display("FAIL reset_hold anode got %b exp %b", anode, exp_anode); else n_pass++;
      n_checks++; if (digit_sel !== 2'd0) $display("FAIL reset_hold digit_sel got %0d exp 0", digit_sel); else n_pass++;
      n_checks++; if (frame_tick !== 1'b0) $display("FAIL reset_hold frame_tick got %b exp 0", frame_tick); else n_pass++;
    end
    #3 reset_n = 1'b1;
    repeat (4) begin
      advance();
      n_checks++; if (anode !== 4'b1111) $display("FAIL idle anode got %b exp 1111", anode); else n_pass++;
      n_checks++; if (digit_sel !== 2'd0) $display("FAIL idle digit_sel got %0d exp 0", digit_sel); else n_pass++;
      n_checks++; if (frame_tick !== 1'b0) $display("FAIL idle frame_tick got %b exp 0", frame_tick); else n_pass++;
    end
  endtask

  task automatic test_full_brightness();
    int ticks = 0;
    int first_tick = -1;
    int gap = -1;
    enable = 1'b0;
    advance();
    brightness = 4'd15;
    digit_en = 4'hf;
    enable = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      advance();
      n_checks++; if (anode !== exp_anode) $display("FAIL full anode i=%0d got %b exp %b", i, anode, exp_anode); else n_pass++;
      n_checks++; if (digit_sel !== exp_sel) $display("FAIL full digit_sel i=%0d got %0d exp %0d", i, digit_sel, exp_sel); else n_pass++;
      n_checks++; if (frame_tick !== exp_ft) $display("FAIL full frame_tick i=%0d got %b exp %b", i, frame_tick, exp_ft); else n_pass++;
      if (i == 3) begin
        n_checks++; if (anode !== 4'b1111) $display("FAIL full last_blank got %b exp 1111", anode); else n_pass++;
      end
      if (i == 4) begin
        n_checks++; if (anode !== 4'b1110) $display("FAIL full first_on got %b exp 1110", anode); else n_pass++;
      end
      if (frame_tick === 1'b1) begin
        ticks++;
        if (first_tick < 0) first_tick = i; else gap = i - first_tick;
      end
    end
    n_checks++; if (ticks != 2) $display("FAIL full tick_count got %0d exp 2", ticks); else n_pass++;
    n_checks++; if (gap != FRAME) $display("FAIL full tick_period got %0d exp %0d", gap, FRAME); else n_pass++;
  endtask

  task automatic test_half_brightness();
    int low[4] = '{0, 0, 0, 0};
    enable = 1'b0;
    advance();
    brightness = 4'd7;
    digit_en = 4'hf;
    enable = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      advance();
      n_checks++; if (anode !== exp_anode) $display("FAIL half anode i=%0d got %b exp %b", i, anode, exp_anode); else n_pass++;
      n_checks++; if (digit_sel !== exp_sel) $display("FAIL half digit_sel i=%0d got %0d exp %0d", i, digit_sel, exp_sel); else n_pass++;
      n_checks++; if (frame_tick !== exp_ft) $display("FAIL half frame_tick i=%0d got %b exp %b", i, frame_tick, exp_ft); else n_pass++;
      if (anode[i / SLOT] === 1'b0) low[i / SLOT]++;
      if (i == SLOT + BC + 5) brightness = 4'd3;
    end
    n_checks++; if (low[0] != 16) $display("FAIL half slot0_on got %0d exp 16", low[0]); else n_pass++;
    n_checks++; if (low[1] != 16) $display("FAIL half slot1_on_midchange got %0d exp 16", low[1]); else n_pass++;
    n_checks++; if (low[2] != 8) $display("FAIL half slot2_on_newduty got %0d exp 8", low[2]); else n_pass++;
  endtask

  task automatic test_masking();
    int off = 0;
    int ticks = 0;
    enable = 1'b0;
    advance();
    brightness = 4'd15;
    digit_en = 4'b0101;
    enable = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      advance();
      n_checks++; if (anode !== exp_anode) $display("FAIL mask anode i=%0d got %b exp %b", i, anode, exp_anode); else n_pass++;
      n_checks++; if (digit_sel !== exp_sel) $display("FAIL mask digit_sel i=%0d got %0d exp %0d", i, digit_sel, exp_sel); else n_pass++;
      n_checks++; if (frame_tick !== exp_ft) $display("FAIL mask frame_tick i=%0d got %b exp %b", i, frame_tick, exp_ft); else n_pass++;
      if (anode === 4'b1111) off++;
      if (frame_tick === 1'b1) ticks++;
    end
    n_checks++; if (off != 2 * SLOT + 2 * BC) $display("FAIL mask off_cycles got %0d exp %0d", off, 2 * SLOT + 2 * BC); else n_pass++;
    n_checks++; if (ticks != 1) $display("FAIL mask tick_count got %0d exp 1", ticks); else n_pass++;
  endtask

  task automatic test_enable_drop();
    enable = 1'b0;
    advance();
    brightness = 4'd15;
    digit_en = 4'hf;
    enable = 1'b1;
    for (int i = 0; i <= 2 * SLOT + BC + 10; i++) begin
      advance();
      n_checks++; if (anode !== exp_anode) $display("FAIL drop_run anode i=%0d got %b exp %b", i, anode, exp_anode); else n_pass++;
      n_checks++; if (digit_sel !== exp_sel) $display("FAIL drop_run digit_sel i=%0d got %0d exp %0d", i, digit_sel, exp_sel); else n_pass++;
    end
    enable = 1'b0;
    advance();
    n_checks++; if (anode !== 4'b1111) $display("FAIL drop anode got %b exp 1111", anode); else n_pass++;
    n_checks++; if (digit_sel !== 2'd0) $display("FAIL drop digit_sel got %0d exp 0", digit_sel); else n_pass++;
    n_checks++; if (frame_tick !== 1'b0) $display("FAIL drop frame_tick got %b exp 0", frame_tick); else n_pass++;
    enable = 1'b1;
    for (int i = 0; i <= BC; i++) begin
      advance();
      n_checks++; if (anode !== ((i < BC) ? 4'b1111 : 4'b1110)) $display("FAIL reenable anode i=%0d got %b", i, anode); else n_pass++;
      n_checks++; if (anode !== exp_anode) $display("FAIL reenable_model anode i=%0d got %b exp %b", i, anode, exp_anode); else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    enable = 1'b0;
    advance();
    brightness = 4'd15;
    digit_en = 4'hf;
    enable = 1'b1;
    for (int i = 0; i <= SLOT + BC + 7; i++) begin
      advance();
      n_checks++; if (anode !== exp_anode) $display("FAIL arst_run anode i=%0d got %b exp %b", i, anode, exp_anode); else n_pass++;
    end
    n_checks++; if (anode !== 4'b1101) $display("FAIL arst_pre anode got %b exp 1101", anode); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (anode !== 4'b1111) $display("FAIL arst anode got %b exp 1111", anode); else n_pass++;
    n_checks++; if (digit_sel !== 2'd0) $display("FAIL arst digit_sel got %0d exp 0", digit_sel); else n_pass++;
    m_active = 1'b0;
    #1 reset_n = 1'b1;
    for (int i = 0; i < SLOT + 2; i++) begin
      advance();
      n_checks++; if (anode !== exp_anode) $display("FAIL arst_after anode i=%0d got %b exp %b", i, anode, exp_anode); else n_pass++;
      n_checks++; if (digit_sel !== exp_sel) $display("FAIL arst_after digit_sel i=%0d got %0d exp %0d", i, digit_sel, exp_sel); else n_pass++;
    end
  endtask

  task automatic test_random();
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) brightness = 4'($urandom);
      if ($urandom_range(0, 29) == 0) digit_en = 4'($urandom);
      enable = ($urandom_range(0, 399) != 0);
      advance();
      n_checks++; if (anode !== exp_anode) $display("FAIL rand anode i=%0d got %b exp %b", i, anode, exp_anode); else n_pass++;
      n_checks++; if (digit_sel !== exp_sel) $display("FAIL rand digit_sel i=%0d got %0d exp %0d", i, digit_sel, exp_sel); else n_pass++;
      n_checks++; if (frame_tick !== exp_ft) $display("FAIL rand frame_tick i=%0d got %b exp %b", i, frame_tick, exp_ft); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_full_brightness();
    test_half_brightness();
    test_masking();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
